uart_arbiter: RTL

Two-port arbiter that shares one UART bus slave (request/rw/wdata/rdata/ready handshake) between two requesters, e.g. CPU data port (A) and debug monitor (B). Round-robin grant, grant held until the UART completes, registered outputs toward both sides. A receive (read) that blocks on an idle RX line is preempted after a programmable timeout when the other requester is waiting, so neither requester can starve the other.

---
 rtl/uart_arbiter_pkg.sv | 27 ++
 rtl/uart_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/uart_arbiter_pkg.sv
// Shared definitions for the two-port UART arbiter: FSM state encoding,
// owner encoding and the round-robin pick used at grant time.
package uart_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DONE    = 2'd2,
    PREEMPT = 2'd3
  } state_e;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // A tie goes to whichever requester did not own the bus last.
  function automatic logic pick_owner(input logic a_req, input logic b_req,
                                      input logic last_owner);
    if (a_req && b_req) begin
      return ~last_owner;
    end else if (a_req) begin
      return OWNER_A;
    end else begin
      return OWNER_B;
    end
  endfunction

endpackage

// File: rtl/uart_arbiter.sv
// Round-robin arbiter sharing one UART slave between requesters A and B,
// with timeout preemption of reads stalled on an idle RX line.
module uart_arbiter
  import uart_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_a_request,
  input  logic        i_a_rw,
  input  logic [31:0] i_a_wdata,
  output logic [31:0] o_a_rdata,
  output logic        o_a_ready,
  input  logic        i_b_request,
  input  logic        i_b_rw,
  input  logic [31:0] i_b_wdata,
  output logic [31:0] o_b_rdata,
  output logic        o_b_ready,
  output logic        o_uart_request,
  output logic        o_uart_rw,
  output logic [31:0] o_uart_wdata,
  input  logic [31:0] i_uart_rdata,
  input  logic        i_uart_ready,
  output logic        o_busy,
  output logic        o_owner
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic PREEMPT_EN = (TIMEOUT > 0);

  state_e        state_q, state_d;
  logic          last_owner_q, last_owner_d;
  logic          owner_q, owner_d;
  logic          busy_q, busy_d;
  logic          uart_req_q, uart_req_d;
  logic          uart_rw_q, uart_rw_d;
  logic [31:0]   uart_wdata_q, uart_wdata_d;
  logic [31:0]   a_rdata_q, a_rdata_d;
  logic [31:0]   b_rdata_q, b_rdata_d;
  logic          a_ready_q, a_ready_d;
  logic          b_ready_q, b_ready_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic grant_owner;
  logic other_req;
  logic timeout_hit;

  assign grant_owner = pick_owner(i_a_request, i_b_request, last_owner_q);
  assign other_req   = (owner_q == OWNER_A) ? i_b_request : i_a_request;
  // The counter parks at LIMIT, so a late-arriving competitor still preempts.
  assign timeout_hit = PREEMPT_EN && (cnt_q == LIMIT) && !uart_rw_q && other_req;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    busy_d       = busy_q;
    uart_req_d   = uart_req_q;
    uart_rw_d    = uart_rw_q;
    uart_wdata_d = uart_wdata_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    a_ready_d    = 1'b0;
    b_ready_d    = 1'b0;
    cnt_d        = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (i_a_request || i_b_request) begin
          owner_d      = grant_owner;
          last_owner_d = grant_owner;
          busy_d       = 1'b1;
          uart_req_d   = 1'b1;
          uart_rw_d    = (grant_owner == OWNER_A) ? i_a_rw : i_b_rw;
          uart_wdata_d = (grant_owner == OWNER_A) ? i_a_wdata : i_b_wdata;
          cnt_d        = '0;
          state_d      = BUSY;
        end
      end

      BUSY: begin
        // Completion takes priority over a timeout in the same cycle.
        if (i_uart_ready) begin
          if (owner_q == OWNER_A) begin
            a_rdata_d = i_uart_rdata;
            a_ready_d = 1'b1;
          end else begin
            b_rdata_d = i_uart_rdata;
            b_ready_d = 1'b1;
          end
          uart_req_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = DONE;
        end else if (timeout_hit) begin
          uart_req_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = PREEMPT;
        end else if (!uart_rw_q && (cnt_q != LIMIT)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      PREEMPT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_B;
      owner_q      <= OWNER_A;
      busy_q       <= 1'b0;
      uart_req_q   <= 1'b0;
      uart_rw_q    <= 1'b0;
      uart_wdata_q <= '0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      a_ready_q    <= 1'b0;
      b_ready_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      uart_req_q   <= uart_req_d;
      uart_rw_q    <= uart_rw_d;
      uart_wdata_q <= uart_wdata_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      a_ready_q    <= a_ready_d;
      b_ready_q    <= b_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_a_rdata      = a_rdata_q;
  assign o_a_ready      = a_ready_q;
  assign o_b_rdata      = b_rdata_q;
  assign o_b_ready      = b_ready_q;
  assign o_uart_request = uart_req_q;
  assign o_uart_rw      = uart_rw_q;
  assign o_uart_wdata   = uart_wdata_q;
  assign o_busy         = busy_q;
  assign o_owner        = owner_q;

endmodule
